wb_commit_state: RTL and testbench

- Write-back-side consumer of the MEM/WB pipeline register outputs.
- Holds the architectural HI/LO pair and the LLbit.
- Provides same-cycle bypassed read views of HI/LO/LLbit to the MEM/EX stages.
- Keeps a write-commit performance counter: one count per WB cycle that performs any architectural write.

---
 rtl/wb_commit_state.sv | 108 ++++++++++
 tb/tb_wb_commit_state.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_state.sv
// Write-back commit state: architectural HI/LO and LLbit with same-cycle bypass views,
// plus a write-commit performance counter with a sticky wrap flag.
module wb_commit_state #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wb_wreg,
  input  logic             wb_whilo,
  input  logic [31:0]      wb_hi,
  input  logic [31:0]      wb_lo,
  input  logic             wb_LLbit_we,
  input  logic             wb_LLbit_value,
  input  logic             wb_cp0_reg_we,
  input  logic             cnt_clr,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic [31:0]      hi_byp_o,
  output logic [31:0]      lo_byp_o,
  output logic             LLbit_o,
  output logic             LLbit_byp_o,
  output logic [CNT_W-1:0] commit_cnt_o,
  output logic             cnt_ovf_o
);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             llbit_q, llbit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             commit;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  assign commit = wb_wreg | wb_whilo | wb_LLbit_we | wb_cp0_reg_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q    <= HILO_RST;
      lo_q    <= HILO_RST;
      llbit_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      llbit_q <= llbit_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // HI/LO commit ignores flush: the WB instruction is older than the excepting one.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_whilo) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end
  end

  always_comb begin
    llbit_d = llbit_q;
    if (flush) begin
      llbit_d = 1'b0;
    end else if (wb_LLbit_we) begin
      llbit_d = wb_LLbit_value;
    end
  end

  // Clear wins over a simultaneous commit; wrap sets the sticky overflow flag.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (cnt_clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (commit) begin
      if (cnt_q == {CNT_W{1'b1}}) begin
        cnt_d = '0;
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_comb begin
    hi_o         = hi_q;
    lo_o         = lo_q;
    LLbit_o      = llbit_q;
    commit_cnt_o = cnt_q;
    cnt_ovf_o    = ovf_q;
    hi_byp_o     = wb_whilo ? wb_hi : hi_q;
    lo_byp_o     = wb_whilo ? wb_lo : lo_q;
    if (flush) begin
      LLbit_byp_o = 1'b0;
    end else if (wb_LLbit_we) begin
      LLbit_byp_o = wb_LLbit_value;
    end else begin
      LLbit_byp_o = llbit_q;
    end
  end

endmodule

// File: tb/tb_wb_commit_state.sv
// Scoreboard bench for wb_commit_state (CNT_W=4): directed vectors push expected views,
// a negedge monitor pops and compares against the DUT outputs.
module tb_wb_commit_state;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0, wb_wreg = 1'b0, wb_whilo = 1'b0;
  logic [31:0] wb_hi = '0, wb_lo = '0;
  logic        wb_LLbit_we = 1'b0, wb_LLbit_value = 1'b0, wb_cp0_reg_we = 1'b0, cnt_clr = 1'b0;
  logic [31:0] hi_o, lo_o, hi_byp_o, lo_byp_o;
  logic        LLbit_o, LLbit_byp_o, cnt_ovf_o;
  logic [3:0]  commit_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] hi, lo, hb, lb;
    logic        ll, llb, ovf;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  wb_commit_state #(
    .CNT_W   (4),
    .HILO_RST(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .wb_wreg       (wb_wreg),
    .wb_whilo      (wb_whilo),
    .wb_hi         (wb_hi),
    .wb_lo         (wb_lo),
    .wb_LLbit_we   (wb_LLbit_we),
    .wb_LLbit_value(wb_LLbit_value),
    .wb_cp0_reg_we (wb_cp0_reg_we),
    .cnt_clr       (cnt_clr),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .hi_byp_o      (hi_byp_o),
    .lo_byp_o      (lo_byp_o),
    .LLbit_o       (LLbit_o),
    .LLbit_byp_o   (LLbit_byp_o),
    .commit_cnt_o  (commit_cnt_o),
    .cnt_ovf_o     (cnt_ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, req);
    end
  endtask

  // Monitor: one expected entry per cycle, compared away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk(cur.name, "hi_o", hi_o, cur.hi);
      chk(cur.name, "lo_o", lo_o, cur.lo);
      chk(cur.name, "hi_byp_o", hi_byp_o, cur.hb);
      chk(cur.name, "lo_byp_o", lo_byp_o, cur.lb);
      chk(cur.name, "LLbit_o", {31'b0, LLbit_o}, {31'b0, cur.ll});
      chk(cur.name, "LLbit_byp_o", {31'b0, LLbit_byp_o}, {31'b0, cur.llb});
      chk(cur.name, "commit_cnt_o", {28'b0, commit_cnt_o}, {28'b0, cur.cnt});
      chk(cur.name, "cnt_ovf_o", {31'b0, cnt_ovf_o}, {31'b0, cur.ovf});
    end
  end

  task automatic cyc(input logic fl, input logic wr, input logic wh, input logic [31:0] h,
                     input logic [31:0] l, input logic lwe, input logic lv, input logic cp,
                     input logic clr);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    flush          = fl;
    wb_wreg        = wr;
    wb_whilo       = wh;
    wb_hi          = h;
    wb_lo          = l;
    wb_LLbit_we    = lwe;
    wb_LLbit_value = lv;
    wb_cp0_reg_we  = cp;
    cnt_clr        = clr;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string name, input logic [31:0] hi, input logic [31:0] lo,
                            input logic [31:0] hb, input logic [31:0] lb, input logic ll,
                            input logic llb, input logic [3:0] cnt, input logic ovf);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.hb = hb; e.lb = lb;
    e.ll = ll; e.llb = llb; e.cnt = cnt; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  initial begin
    // Cycle under reset, then load HI=1234 so the async reset has something to discard.
    @(posedge clk);
    #1;
    expect_out("in_reset", 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h1234, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("preload_byp", 0, 0, 32'h1234, 32'h55, 1'b0, 1'b0, 4'd0, 1'b0);
    idle();
    expect_out("preload_reg", 32'h1234, 32'h55, 32'h1234, 32'h55, 1'b0, 1'b0, 4'd1, 1'b0);
    idle();
    #2 rst = 1'b1;
    expect_out("async_reset", 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle();
    expect_out("reset_release", 0, 0, 0, 0, 1'b0, 1'b0, 4'd0, 1'b0);

    // HI/LO commit and bypass
    cyc(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("hilo_byp", 0, 0, 32'hDEADBEEF, 32'h5, 1'b0, 1'b0, 4'd0, 1'b0);
    idle();
    expect_out("hilo_reg", 32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h5, 1'b0, 1'b0, 4'd1, 1'b0);
    idle();
    expect_out("hilo_hold", 32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h5, 1'b0, 1'b0, 4'd1, 1'b0);

    // LLbit set, then flush beats a simultaneous LLbit write
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("ll_set_byp", 32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h5, 1'b0, 1'b1, 4'd1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("ll_flush_byp", 32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h5, 1'b1, 1'b0, 4'd2, 1'b0);
    idle();
    expect_out("ll_flush_reg", 32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h5, 1'b0, 1'b0, 4'd3, 1'b0);

    // Bubbles are not counted; GPR+CP0 write in one cycle counts once
    for (int i = 0; i < 5; i++) begin
      idle();
      expect_out("bubble", 32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h5, 1'b0, 1'b0, 4'd3, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("wreg_cp0", 32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h5, 1'b0, 1'b0, 4'd3, 1'b0);
    idle();
    expect_out("wreg_cp0_cnt", 32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h5, 1'b0, 1'b0, 4'd4, 1'b0);

    // Flush does not suppress an HI/LO commit
    cyc(1'b1, 1'b0, 1'b1, 32'h7, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("flush_hilo_byp", 32'hDEADBEEF, 32'h5, 32'h7, 32'h8, 1'b0, 1'b0, 4'd4, 1'b0);
    idle();
    expect_out("flush_hilo_reg", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0, 1'b0, 4'd5, 1'b0);

    // Clear, then count up to wrap
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("clr_pre", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0, 1'b0, 4'd5, 1'b0);
    idle();
    expect_out("clr_done", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("count_up", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0, 1'b0, 4'(i), 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("wrapped", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0, 1'b0, 4'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("ovf_sticky", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0, 1'b0, 4'd1, 1'b1);
    idle();
    expect_out("clr_beats_commit", 32'h7, 32'h8, 32'h7, 32'h8, 1'b0, 1'b0, 4'd0, 1'b0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
